mem_port_arbiter: RTL

Shares one single-port memory between the instruction-fetch and data-access stages of the 5-stage RISC-V core. Each transaction is serialised through a handshake FSM, with the data port having priority by default. The block produces per-stage stall signals that the core uses to freeze the PC, IF/ID and later pipeline registers. It sits between the IF/MEM stages and the unified memory model.

---
 rtl/mem_port_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch and data
// stages of the core. One transaction at a time runs through a handshake FSM,
// with the data port winning ties. Per-stage stall flags freeze the pipeline.
//
// Optional build macro ARB_STARVE_GUARD_EN: adds a deny counter that forces a
// fetch grant after MAX_DENY consecutive data grants made while a fetch waits.
// Without it, data priority is strict and fetch may starve.
//
// state  | meaning
// IDLE   | no transaction; arbitrate between i_req and d_req
// WAIT_I | fetch command on m_*, waiting for m_ack
// WAIT_D | data command on m_*, waiting for m_ack
// RESP   | ready pulse to the owner; no arbitration this cycle

module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_DENY = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ready,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_be,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ack,
    output logic                m_src,
    output logic                if_stall,
    output logic                mem_stall
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic   grant_i;
    logic   grant_d;
    logic   force_fetch;

    // A deny limit of zero would lock data out entirely; refuse to elaborate it.
    generate
        if (MAX_DENY < 1) begin : g_bad_max_deny
            $error("mem_port_arbiter: MAX_DENY must be at least 1");
        end
    endgenerate

`ifdef ARB_STARVE_GUARD_EN
    localparam int               CNT_W    = $clog2(MAX_DENY + 1);
    localparam logic [CNT_W-1:0] DENY_MAX = CNT_W'(MAX_DENY);

    logic [CNT_W-1:0] deny_cnt;

    // Count data grants that bypassed a waiting fetch; saturate at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            deny_cnt <= '0;
        end else if (grant_i) begin
            deny_cnt <= '0;
        end else if (grant_d) begin
            if (!i_req) begin
                deny_cnt <= '0;
            end else if (deny_cnt != DENY_MAX) begin
                deny_cnt <= deny_cnt + CNT_W'(1);
            end
        end
    end

    assign force_fetch = i_req && (deny_cnt == DENY_MAX);
`else
    assign force_fetch = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and grant decode; data wins unless the guard forces fetch.
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !force_fetch) begin
                    grant_d    = 1'b1;
                    state_next = WAIT_D;
                end else if (i_req) begin
                    grant_i    = 1'b1;
                    state_next = WAIT_I;
                end
            end
            WAIT_I: begin
                if (m_ack) begin
                    state_next = RESP;
                end
            end
            WAIT_D: begin
                if (m_ack) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Memory command, read-data capture and ready pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_be    <= '0;
            m_src   <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
            i_ready <= 1'b0;
            d_ready <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        m_req   <= 1'b1;
                        m_src   <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        m_be    <= d_be;
                    end else if (grant_i) begin
                        m_req   <= 1'b1;
                        m_src   <= 1'b0;
                        m_we    <= 1'b0;
                        m_addr  <= i_addr;
                        m_wdata <= '0;
                        m_be    <= '1;
                    end
                end
                WAIT_I: begin
                    if (m_ack) begin
                        m_req   <= 1'b0;
                        i_rdata <= m_rdata;
                        i_ready <= 1'b1;
                    end
                end
                WAIT_D: begin
                    if (m_ack) begin
                        m_req   <= 1'b0;
                        d_ready <= 1'b1;
                        // Stores leave the last load data in place.
                        if (!m_we) begin
                            d_rdata <= m_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign if_stall  = i_req & ~i_ready;
    assign mem_stall = d_req & ~d_ready;

endmodule
